plru_victim_sel: RTL and testbench

PLRU_VICTIM_SEL -- requirements
Module: plru_victim_sel

---
 rtl/plru_victim_sel_pkg.sv | 19 +
 rtl/way_prio_enc.sv | 17 +
 rtl/plru_victim_sel.sv | 127 ++++++++++++
 tb/tb_plru_victim_sel.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/plru_victim_sel_pkg.sv
// Shared types and constants for the tree-PLRU victim selector.
// The typedefs describe the default 4-way, 64-set configuration.
package plru_victim_sel_pkg;

  localparam int unsigned DEF_LOG_WAYS = 2;
  localparam int unsigned DEF_LOG_SETS = 6;
  localparam int unsigned DEF_WAYS     = 2 ** DEF_LOG_WAYS;
  localparam int unsigned PLRU_NODES   = DEF_WAYS - 1;

  typedef logic [DEF_LOG_WAYS-1:0] way_idx_t;
  typedef logic [DEF_LOG_SETS-1:0] set_idx_t;
  typedef logic [PLRU_NODES-1:0]   plru_vec_t;

  // Returns the number of tree nodes needed for a given associativity.
  function automatic int unsigned plru_nodes(input int unsigned log_ways);
    return (2 ** log_ways) - 1;
  endfunction

endpackage

// File: rtl/way_prio_enc.sv
// Highest-set-bit encoder over WAYS request bits; all-zero input gives 0.
module way_prio_enc #(
  parameter int unsigned LOG_WAYS = 2,
  parameter int unsigned WAYS     = 2 ** LOG_WAYS
) (
  input  logic [WAYS-1:0]     bits,
  output logic [LOG_WAYS-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (bits[i]) idx = LOG_WAYS'(i);
    end
  end

endmodule

// File: rtl/plru_victim_sel.sv
// Tree-PLRU victim selector with per-set recency state and a one-deep response register.
// Define VICTIM_INVALID_FIRST_EN to prefer the highest-index invalid way over the PLRU walk.
module plru_victim_sel
  import plru_victim_sel_pkg::*;
#(
  parameter int unsigned LOG_WAYS = DEF_LOG_WAYS,
  parameter int unsigned LOG_SETS = DEF_LOG_SETS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [LOG_SETS-1:0]       req_set,
  input  logic [(2**LOG_WAYS)-1:0]  req_invalid,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [LOG_WAYS-1:0]       rsp_way,
  output logic                      rsp_from_invalid,
  input  logic                      touch_valid,
  input  logic [LOG_SETS-1:0]       touch_set,
  input  logic [LOG_WAYS-1:0]       touch_way
);

  localparam int unsigned WAYS  = 2 ** LOG_WAYS;
  localparam int unsigned SETS  = 2 ** LOG_SETS;
  localparam int unsigned NODES = plru_nodes(LOG_WAYS);
  localparam int unsigned IW    = (NODES > 1) ? $clog2(NODES) : 1;

  logic [NODES-1:0] plru [SETS];

  logic [NODES-1:0]    touched_tree;
  logic [NODES-1:0]    lookup_tree;
  logic [LOG_WAYS-1:0] plru_way;
  logic [LOG_WAYS-1:0] victim_way;
  logic                victim_from_invalid;
  logic                req_fire;

  // Walk from the root: bit 0 goes left (lower ways), bit 1 goes right.
  function automatic logic [LOG_WAYS-1:0] plru_walk(input logic [NODES-1:0] t);
    int unsigned         n;
    logic                b;
    logic [LOG_WAYS-1:0] w;
    n = 0;
    w = '0;
    for (int unsigned l = 0; l < LOG_WAYS; l++) begin
      b = t[IW'(n)];
      w = (w << 1) | LOG_WAYS'(b);
      n = 2 * n + (b ? 32'd2 : 32'd1);
    end
    return w;
  endfunction

  // Every node on the path to the touched way is pointed at the other half.
  function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] t,
                                                  input logic [LOG_WAYS-1:0] way);
    int unsigned         n;
    logic                b;
    logic [LOG_WAYS-1:0] w;
    logic [NODES-1:0]    r;
    n = 0;
    w = way;
    r = t;
    for (int unsigned l = 0; l < LOG_WAYS; l++) begin
      b = w[LOG_WAYS-1];
      w = w << 1;
      r[IW'(n)] = ~b;
      n = 2 * n + (b ? 32'd2 : 32'd1);
    end
    return r;
  endfunction

  assign req_ready = !rsp_valid || rsp_ready;
  assign req_fire  = req_valid && req_ready;

  // Same-set touch is forwarded so the lookup sees the post-touch tree.
  always_comb begin
    touched_tree = plru_touch(plru[touch_set], touch_way);
    lookup_tree  = plru[req_set];
    if (touch_valid && (touch_set == req_set)) lookup_tree = touched_tree;
    plru_way = plru_walk(lookup_tree);
  end

`ifdef VICTIM_INVALID_FIRST_EN
  logic [LOG_WAYS-1:0] inv_way;

  way_prio_enc #(
    .LOG_WAYS (LOG_WAYS),
    .WAYS     (WAYS)
  ) u_prio_enc (
    .bits (req_invalid),
    .idx  (inv_way)
  );

  always_comb begin
    victim_from_invalid = |req_invalid;
    victim_way          = victim_from_invalid ? inv_way : plru_way;
  end
`else
  logic unused_invalid;
  assign unused_invalid      = ^req_invalid;
  assign victim_from_invalid = 1'b0;
  assign victim_way          = plru_way;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned s = 0; s < SETS; s++) plru[s] <= '0;
    end else if (touch_valid) begin
      plru[touch_set] <= touched_tree;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid        <= 1'b0;
      rsp_way          <= '0;
      rsp_from_invalid <= 1'b0;
    end else if (req_fire) begin
      rsp_valid        <= 1'b1;
      rsp_way          <= victim_way;
      rsp_from_invalid <= victim_from_invalid;
    end else if (rsp_ready) begin
      rsp_valid        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_plru_victim_sel.sv
// Directed self-checking bench for plru_victim_sel (4 ways, 64 sets).
module tb_plru_victim_sel;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_set;
  logic [3:0] req_invalid;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_way;
  logic       rsp_from_invalid;
  logic       touch_valid;
  logic [5:0] touch_set;
  logic [1:0] touch_way;

  int tests = 0;
  int fails = 0;

  plru_victim_sel #(.LOG_WAYS(2), .LOG_SETS(6)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_set          (req_set),
    .req_invalid      (req_invalid),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_way          (rsp_way),
    .rsp_from_invalid (rsp_from_invalid),
    .touch_valid      (touch_valid),
    .touch_set        (touch_set),
    .touch_way        (touch_way)
  );

  always #5 clk = ~clk;

  task automatic issue_req(input logic [5:0] s, input logic [3:0] inv);
    req_valid   = 1'b1;
    req_set     = s;
    req_invalid = inv;
    @(negedge clk);
    req_valid   = 1'b0;
  endtask

  task automatic do_touch(input logic [5:0] s, input logic [1:0] w);
    touch_valid = 1'b1;
    touch_set   = s;
    touch_way   = w;
    @(negedge clk);
    touch_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b exp 0", rsp_valid); end
    tests++; if (rsp_way !== 2'd0) begin fails++; $display("FAIL reset_way got %0d exp 0", rsp_way); end
    tests++; if (rsp_from_invalid !== 1'b0) begin fails++; $display("FAIL reset_from_inv got %0b exp 0", rsp_from_invalid); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %0b exp 1", req_ready); end
  endtask

  task automatic test_basic();
    logic [1:0] exp_way;
    logic       exp_inv;
    issue_req(6'd5, 4'b0000);
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %0b exp 1", rsp_valid); end
    tests++; if (rsp_way !== 2'd0) begin fails++; $display("FAIL basic_way got %0d exp 0", rsp_way); end
    tests++; if (rsp_from_invalid !== 1'b0) begin fails++; $display("FAIL basic_from_inv got %0b exp 0", rsp_from_invalid); end
`ifdef VICTIM_INVALID_FIRST_EN
    exp_way = 2'd3; exp_inv = 1'b1;
`else
    exp_way = 2'd0; exp_inv = 1'b0;
`endif
    issue_req(6'd5, 4'b1001);
    tests++; if (rsp_way !== exp_way) begin fails++; $display("FAIL invalid_way got %0d exp %0d", rsp_way, exp_way); end
    tests++; if (rsp_from_invalid !== exp_inv) begin fails++; $display("FAIL invalid_from_inv got %0b exp %0b", rsp_from_invalid, exp_inv); end
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL basic_clear got %0b exp 0", rsp_valid); end
  endtask

  task automatic test_touch();
    do_touch(6'd5, 2'd0);
    issue_req(6'd5, 4'b0000);
    tests++; if (rsp_way !== 2'd2) begin fails++; $display("FAIL touch0_way got %0d exp 2", rsp_way); end
    do_touch(6'd5, 2'd2);
    issue_req(6'd5, 4'b0000);
    tests++; if (rsp_way !== 2'd1) begin fails++; $display("FAIL touch2_way got %0d exp 1", rsp_way); end
    do_touch(6'd5, 2'd1);
    issue_req(6'd5, 4'b0000);
    tests++; if (rsp_way !== 2'd3) begin fails++; $display("FAIL touch1_way got %0d exp 3", rsp_way); end
    issue_req(6'd6, 4'b0000);
    tests++; if (rsp_way !== 2'd0) begin fails++; $display("FAIL other_set_way got %0d exp 0", rsp_way); end
    // A returned victim must leave the tree untouched.
    issue_req(6'd5, 4'b0000);
    tests++; if (rsp_way !== 2'd3) begin fails++; $display("FAIL no_update_way got %0d exp 3", rsp_way); end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    issue_req(6'd5, 4'b0000);
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_valid got %0b exp 1", rsp_valid); end
    tests++; if (rsp_way !== 2'd3) begin fails++; $display("FAIL bp_way got %0d exp 3", rsp_way); end
    do_touch(6'd5, 2'd3);
    for (int i = 0; i < 2; i++) begin
      tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL bp_ready cyc %0d got %0b exp 0", i, req_ready); end
      tests++; if (rsp_way !== 2'd3) begin fails++; $display("FAIL bp_hold cyc %0d got %0d exp 3", i, rsp_way); end
      tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid cyc %0d got %0b exp 1", i, rsp_valid); end
      if (i == 0) @(negedge clk);
    end
    rsp_ready   = 1'b1;
    req_valid   = 1'b1;
    req_set     = 6'd6;
    req_invalid = 4'b0000;
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL release_ready got %0b exp 1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL release_valid got %0b exp 1", rsp_valid); end
    tests++; if (rsp_way !== 2'd0) begin fails++; $display("FAIL release_way got %0d exp 0", rsp_way); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [5:0] sets [3];
    logic [1:0] exps [3];
    do_touch(6'd7, 2'd0);
    do_touch(6'd9, 2'd0);
    do_touch(6'd9, 2'd2);
    sets[0] = 6'd7; exps[0] = 2'd2;
    sets[1] = 6'd9; exps[1] = 2'd1;
    sets[2] = 6'd5; exps[2] = 2'd0;
    req_valid   = 1'b1;
    req_invalid = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      req_set = sets[i];
      @(negedge clk);
      tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid %0d got %0b exp 1", i, rsp_valid); end
      tests++; if (rsp_way !== exps[i]) begin fails++; $display("FAIL b2b_way %0d got %0d exp %0d", i, rsp_way, exps[i]); end
    end
    req_valid = 1'b0;
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL b2b_clear got %0b exp 0", rsp_valid); end
  endtask

  task automatic test_forward();
    apply_reset();
    touch_valid = 1'b1;
    touch_set   = 6'd5;
    touch_way   = 2'd0;
    issue_req(6'd5, 4'b0000);
    touch_valid = 1'b0;
    tests++; if (rsp_way !== 2'd2) begin fails++; $display("FAIL forward_way got %0d exp 2", rsp_way); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    rsp_ready = 1'b0;
    do_touch(6'd5, 2'd0);
    issue_req(6'd5, 4'b0000);
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL mid_pre_valid got %0b exp 1", rsp_valid); end
    tests++; if (rsp_way !== 2'd2) begin fails++; $display("FAIL mid_pre_way got %0d exp 2", rsp_way); end
    req_valid   = 1'b1;
    req_set     = 6'd5;
    req_invalid = 4'b0000;
    reset       = 1'b1;
    #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_async_valid got %0b exp 0", rsp_valid); end
    tests++; if (rsp_way !== 2'd0) begin fails++; $display("FAIL mid_async_way got %0d exp 0", rsp_way); end
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_no_rsp got %0b exp 0", rsp_valid); end
    issue_req(6'd5, 4'b0000);
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL mid_after_valid got %0b exp 1", rsp_valid); end
    tests++; if (rsp_way !== 2'd0) begin fails++; $display("FAIL mid_after_way got %0d exp 0", rsp_way); end
    @(negedge clk);
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_set     = '0;
    req_invalid = '0;
    rsp_ready   = 1'b1;
    touch_valid = 1'b0;
    touch_set   = '0;
    touch_way   = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_touch();
    test_backpressure();
    test_back_to_back();
    test_forward();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
